// File: rtl/gen_pipe_stage.sv
// One elastic pipeline slot: a valid bit plus a data word, loaded with def_val on reset/flush.
// An empty slot always accepts, so bubbles collapse as the pipe drains.
module gen_pipe_stage #(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [DW-1:0] def_val,
  input  logic          up_valid,
  input  logic [DW-1:0] up_data,
  input  logic          dn_ready,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic          up_ready
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  assign up_ready = !valid_q || dn_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (!rst || flush) begin
      valid_d = 1'b0;
      data_d  = def_val;
    end else if (up_ready) begin
      valid_d = up_valid;
      // Data is held across bubbles so qout never glitches to garbage.
      if (up_valid) data_d = up_data;
    end
  end

  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    data_q  <= data_d;
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/gen_pipe_elastic.sv
// Elastic valid/ready pipeline of DEPTH slots with optional input skid buffer,
// synchronous flush to def_val and a registered occupancy count.
module gen_pipe_elastic #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned SKID  = 0,
  parameter int unsigned CW    = $clog2(DEPTH + 2)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [DW-1:0] def_val,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] din,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] qout,
  output logic [CW-1:0] count
);

  if (DEPTH < 1) begin : g_depth_check
    $error("gen_pipe_elastic: DEPTH must be at least 1");
  end

  logic          live;
  logic          s0_valid;
  logic [DW-1:0] s0_data;
  logic          s0_ready;
  logic [DEPTH-1:0] stg_v;
  logic [DW-1:0]    stg_d [DEPTH];

  assign live = rst && !flush;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic          up_valid_k;
    logic [DW-1:0] up_data_k;
    logic          dn_rdy;
    logic          up_rdy;

    if (k == 0) begin : g_first
      assign up_valid_k = s0_valid;
      assign up_data_k  = s0_data;
      assign s0_ready   = up_rdy;
    end else begin : g_next
      assign up_valid_k = stg_v[k-1];
      assign up_data_k  = stg_d[k-1];
    end

    if (k == DEPTH - 1) begin : g_last
      assign dn_rdy = out_ready;
    end else begin : g_mid
      assign dn_rdy = g_stage[k+1].up_rdy;
    end

    gen_pipe_stage #(
      .DW(DW)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .def_val  (def_val),
      .up_valid (up_valid_k),
      .up_data  (up_data_k),
      .dn_ready (dn_rdy),
      .valid    (stg_v[k]),
      .data     (stg_d[k]),
      .up_ready (up_rdy)
    );
  end

  if (SKID != 0) begin : g_skid
    logic          sv_q, sv_d;
    logic [DW-1:0] sd_q, sd_d;

    // in_ready depends only on the skid register, never on out_ready.
    assign in_ready = live && !sv_q;
    assign s0_valid = sv_q || in_valid;
    assign s0_data  = sv_q ? sd_q : din;

    always_comb begin
      sv_d = sv_q;
      sd_d = sd_q;
      if (!live) begin
        sv_d = 1'b0;
        sd_d = def_val;
      end else if (sv_q && s0_ready) begin
        sv_d = 1'b0;
      end else if (in_valid && in_ready && !s0_ready) begin
        sv_d = 1'b1;
        sd_d = din;
      end
    end

    always_ff @(posedge clk) begin
      sv_q <= sv_d;
      sd_q <= sd_d;
    end
  end else begin : g_noskid
    assign in_ready = live && s0_ready;
    assign s0_valid = in_valid;
    assign s0_data  = din;
  end

  logic          in_acc, out_acc;
  logic [CW-1:0] cnt_q, cnt_d;

  assign in_acc  = in_valid && in_ready;
  assign out_acc = out_valid && out_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (!live) begin
      cnt_d = '0;
    end else begin
      unique case ({in_acc, out_acc})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign count     = cnt_q;
  assign out_valid = stg_v[DEPTH-1];
  assign qout      = stg_d[DEPTH-1];

endmodule
